// File: rtl/umi_xbar_pkg.sv
// Shared definitions for the UMI crossbar ingress path: ID-field defaults,
// the buffered entry layout at default widths, and the occupancy state encoding.
package umi_xbar_pkg;

  localparam int UMI_N     = 4;
  localparam int UMI_CW    = 32;
  localparam int UMI_AW    = 64;
  localparam int UMI_DW    = 256;
  localparam int IDLSB_DEF = 40;
  localparam int IDW_DEF   = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } cnt_state_e;

  typedef struct packed {
    logic [UMI_CW-1:0] cmd;
    logic [UMI_AW-1:0] dstaddr;
    logic [UMI_AW-1:0] srcaddr;
    logic [UMI_DW-1:0] data;
    logic [UMI_N-1:0]  req;
  } entry_t;

endpackage

// File: rtl/umi_xbar_ingress_if.sv
// Packet stream into and out of one ingress port; master drives the input
// stream and the downstream accept, slave is the ingress buffer itself.
interface umi_xbar_ingress_if #(
  parameter int N  = 4,
  parameter int CW = 32,
  parameter int AW = 64,
  parameter int DW = 256
);

  logic          umi_in_valid;
  logic          umi_in_ready;
  logic [CW-1:0] umi_in_cmd;
  logic [AW-1:0] umi_in_dstaddr;
  logic [AW-1:0] umi_in_srcaddr;
  logic [DW-1:0] umi_in_data;

  logic          umi_out_valid;
  logic [N-1:0]  umi_out_request;
  logic          umi_out_ready;
  logic [CW-1:0] umi_out_cmd;
  logic [AW-1:0] umi_out_dstaddr;
  logic [AW-1:0] umi_out_srcaddr;
  logic [DW-1:0] umi_out_data;

  modport master (
    output umi_in_valid, umi_in_cmd, umi_in_dstaddr, umi_in_srcaddr, umi_in_data,
    output umi_out_ready,
    input  umi_in_ready,
    input  umi_out_valid, umi_out_request, umi_out_cmd, umi_out_dstaddr,
    input  umi_out_srcaddr, umi_out_data
  );

  modport slave (
    input  umi_in_valid, umi_in_cmd, umi_in_dstaddr, umi_in_srcaddr, umi_in_data,
    input  umi_out_ready,
    output umi_in_ready,
    output umi_out_valid, umi_out_request, umi_out_cmd, umi_out_dstaddr,
    output umi_out_srcaddr, umi_out_data
  );

endinterface

// File: rtl/umi_xbar_decode.sv
// Combinational destination decode: dstaddr ID field to one-hot request.
// Out-of-range IDs raise o_oor and select the default port.
module umi_xbar_decode
  import umi_xbar_pkg::*;
#(
  parameter int N       = UMI_N,
  parameter int AW      = UMI_AW,
  parameter int IDLSB   = IDLSB_DEF,
  parameter int IDW     = IDW_DEF,
  parameter int DEFPORT = 0
) (
  input  logic [AW-1:0] i_dstaddr,
  output logic [N-1:0]  o_request,
  output logic          o_oor
);

  logic [IDW-1:0] w_id;
  logic           w_unused_addr;

  assign w_id          = i_dstaddr[IDLSB +: IDW];
  assign w_unused_addr = ^i_dstaddr;

  always_comb begin
    o_request = '0;
    o_oor     = (w_id >= IDW'(N));
    for (int j = 0; j < N; j++) begin
      if (w_id == IDW'(j)) o_request[j] = 1'b1;
    end
    if (o_oor) o_request[DEFPORT] = 1'b1;
  end

endmodule

// File: rtl/umi_xbar_ingress.sv
// Per-port crossbar ingress: 2-entry skid FIFO with request decoded at write time.
// Build option UMI_INGRESS_ERR_EN drops out-of-range IDs and reports them on err_*.
module umi_xbar_ingress
  import umi_xbar_pkg::*;
#(
  parameter int N       = UMI_N,
  parameter int CW      = UMI_CW,
  parameter int AW      = UMI_AW,
  parameter int DW      = UMI_DW,
  parameter int IDLSB   = IDLSB_DEF,
  parameter int IDW     = IDW_DEF,
  parameter int DEFPORT = 0
) (
  input  logic               clk,
  input  logic               reset,
  umi_xbar_ingress_if.slave  umi
`ifdef UMI_INGRESS_ERR_EN
  ,
  output logic               err_valid,
  output logic [15:0]        err_count
`endif
);

  typedef struct packed {
    logic [CW-1:0] cmd;
    logic [AW-1:0] dstaddr;
    logic [AW-1:0] srcaddr;
    logic [DW-1:0] data;
    logic [N-1:0]  req;
  } slot_t;

  slot_t      r_mem [2];
  cnt_state_e r_state;
  cnt_state_e w_state_nxt;
  logic       r_wptr;
  logic       r_rptr;
  logic       r_in_ready;
  logic       w_push;
  logic       w_wr;
  logic       w_pop;
  logic       w_out_valid;
  logic       w_oor;
  logic [N-1:0] w_req;

  umi_xbar_decode #(
    .N       (N),
    .AW      (AW),
    .IDLSB   (IDLSB),
    .IDW     (IDW),
    .DEFPORT (DEFPORT)
  ) u_decode (
    .i_dstaddr (umi.umi_in_dstaddr),
    .o_request (w_req),
    .o_oor     (w_oor)
  );

  assign w_push      = umi.umi_in_valid & r_in_ready;
  assign w_out_valid = (r_state != EMPTY);
  assign w_pop       = w_out_valid & umi.umi_out_ready;

`ifdef UMI_INGRESS_ERR_EN
  logic        r_err_valid;
  logic [15:0] r_err_count;

  // Out-of-range packets are consumed at the input but never occupy a slot.
  assign w_wr = w_push & ~w_oor;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_valid <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_err_valid <= w_push & w_oor;
      if (w_push && w_oor && (r_err_count != 16'hFFFF)) r_err_count <= r_err_count + 16'd1;
    end
  end

  assign err_valid = r_err_valid;
  assign err_count = r_err_count;
`else
  logic w_oor_unused;
  assign w_wr         = w_push;
  assign w_oor_unused = w_oor;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY:   if (w_wr) w_state_nxt = ONE;
      ONE: begin
        if (w_wr && !w_pop)      w_state_nxt = FULL;
        else if (!w_wr && w_pop) w_state_nxt = EMPTY;
      end
      FULL:    if (w_pop) w_state_nxt = ONE;
      default: w_state_nxt = EMPTY;
    endcase
  end

  // Ready is registered from the next state so out_ready never reaches in_ready combinationally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= EMPTY;
      r_wptr     <= 1'b0;
      r_rptr     <= 1'b0;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != FULL);
      if (w_wr)  r_wptr <= ~r_wptr;
      if (w_pop) r_rptr <= ~r_rptr;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wptr] <= {umi.umi_in_cmd, umi.umi_in_dstaddr, umi.umi_in_srcaddr,
                        umi.umi_in_data, w_req};
    end
  end

  assign umi.umi_in_ready    = r_in_ready;
  assign umi.umi_out_valid   = w_out_valid;
  assign umi.umi_out_request = w_out_valid ? r_mem[r_rptr].req : '0;
  assign umi.umi_out_cmd     = r_mem[r_rptr].cmd;
  assign umi.umi_out_dstaddr = r_mem[r_rptr].dstaddr;
  assign umi.umi_out_srcaddr = r_mem[r_rptr].srcaddr;
  assign umi.umi_out_data    = r_mem[r_rptr].data;

endmodule
